// File: rtl/quaternion_ts_fifo.sv
// rtl/quaternion_ts_fifo.sv - timestamped quaternion FIFO with sticky error flags and optional drop-oldest mode
// Optional macro QTS_FIFO_STATS_EN adds drop_cnt and peak_cnt statistics outputs.
module quaternion_ts_fifo #(
  parameter int DATA_W       = 64,
  parameter int TS_W         = 32,
  parameter int DEPTH        = 16,
  parameter int PTR_W        = $clog2(DEPTH),
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int OVERWRITE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [TS_W-1:0]   ts_in,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic [TS_W-1:0]   ts_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow
`ifdef QTS_FIFO_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [PTR_W:0]    peak_cnt
`endif
);

  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   AFULL_C  = (PTR_W+1)'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic             OVW      = (OVERWRITE != 0);

  logic [TS_W+DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         cnt;
  logic                   rd_fire;
  logic                   wr_fire;
  logic                   ovf_evt;
  logic                   unf_evt;
  logic                   ovw_pop;
  logic                   cnt_inc;

  assign count       = cnt;
  assign full        = (cnt == DEPTH_C);
  assign empty       = (cnt == '0);
  assign almost_full = (cnt >= AFULL_C);

  // flush masks both requests so it never counts as an error event
  assign rd_fire = rd_en & ~empty & ~flush;
  assign wr_fire = wr_en & ~flush & (~full | rd_fire | OVW);
  assign ovf_evt = wr_en & ~flush & full & ~rd_fire;
  assign unf_evt = rd_en & ~flush & empty;
  assign ovw_pop = ovf_evt & OVW;
  assign cnt_inc = wr_fire & ~ovw_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= {ts_in, data_in};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      data_out  <= '0;
      ts_out    <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid_out <= rd_fire;
      if (rd_fire) {ts_out, data_out} <= mem[rd_ptr];

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_fire) wr_ptr <= ptr_next(wr_ptr);
        // in drop-oldest mode the read side steps past the overwritten entry
        if (rd_fire | ovw_pop) rd_ptr <= ptr_next(rd_ptr);
        if (cnt_inc & ~rd_fire) cnt <= cnt + 1'b1;
        else if (rd_fire & ~cnt_inc) cnt <= cnt - 1'b1;
      end

      if (ovf_evt) overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_evt) underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

`ifdef QTS_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr_err) begin
      drop_cnt <= '0;
      peak_cnt <= '0;
    end else begin
      if (ovf_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      if (cnt > peak_cnt) peak_cnt <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_quaternion_ts_fifo.sv
// tb/tb_quaternion_ts_fifo.sv - directed bench for quaternion_ts_fifo, both overwrite modes side by side
module tb_quaternion_ts_fifo;
  logic        clk = 1'b0;
  logic        rst_n, wr_en, rd_en, flush, clr_err;
  logic [63:0] data_in;
  logic [31:0] ts_in;

  logic [63:0] d0, d1;
  logic [31:0] t0, t1;
  logic        v0, v1, f0, f1, e0, e1, af0, af1, ov0, ov1, un0, un1;
  logic [4:0]  c0, c1;
`ifdef QTS_FIFO_STATS_EN
  logic [15:0] dc0, dc1;
  logic [4:0]  pk0, pk1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quaternion_ts_fifo #(.OVERWRITE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .ts_in(ts_in),
    .rd_en(rd_en), .flush(flush), .clr_err(clr_err), .data_out(d0), .ts_out(t0),
    .valid_out(v0), .full(f0), .empty(e0), .almost_full(af0), .count(c0),
    .overflow(ov0), .underflow(un0)
`ifdef QTS_FIFO_STATS_EN
    , .drop_cnt(dc0), .peak_cnt(pk0)
`endif
  );

  quaternion_ts_fifo #(.OVERWRITE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .ts_in(ts_in),
    .rd_en(rd_en), .flush(flush), .clr_err(clr_err), .data_out(d1), .ts_out(t1),
    .valid_out(v1), .full(f1), .empty(e1), .almost_full(af1), .count(c1),
    .overflow(ov1), .underflow(un1)
`ifdef QTS_FIFO_STATS_EN
    , .drop_cnt(dc1), .peak_cnt(pk1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] qdata(input int k);
    return {48'h1111_2222_3333, 16'(k)};
  endfunction

  task automatic set_wr(input int k);
    data_in = qdata(k);
    ts_in   = 32'(k);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    data_in = '0; ts_in = '0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_count", c0, 0);
    chk("rst_empty", e0, 1);
    chk("rst_full", f0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_ovf", ov0, 0);
    chk("rst_dout", d0, 0);

    // three writes, three reads
    wr_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_wr(k * 10);
      step();
    end
    wr_en = 1'b0;
    chk("w3_count", c0, 3);
    chk("w3_valid", v0, 0);
    rd_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("r3_valid", v0, 1);
      chk("r3_ts", t0, 64'(k * 10));
      chk("r3_data", d0, qdata(k * 10));
      chk("r3_count", c0, 64'(3 - k));
    end
    rd_en = 1'b0;
    step();
    chk("r3_valid_drop", v0, 0);
    chk("r3_empty", e0, 1);
    chk("r3_ts_hold", t0, 30);
    chk("r3_unf", un0, 0);

    // 17 writes into a 16-deep FIFO
    wr_en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      set_wr(k);
      step();
      if (k == 13) chk("af_at_14", af0, 1);
      if (k == 12) chk("af_at_13", af0, 0);
    end
    wr_en = 1'b0;
    chk("ow0_full", f0, 1);
    chk("ow0_ovf", ov0, 1);
    chk("ow0_count", c0, 16);
    chk("ow1_full", f1, 1);
    chk("ow1_ovf", ov1, 1);
    chk("ow1_count", c1, 16);
`ifdef QTS_FIFO_STATS_EN
    chk("ow0_drop", dc0, 1);
    chk("ow1_drop", dc1, 1);
    chk("ow0_peak", pk0, 16);
`endif
    rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("ow0_rd_ts", t0, 64'(k));
      chk("ow1_rd_ts", t1, 64'(k + 1));
    end
    rd_en = 1'b0;
    step();
    chk("ow0_empty", e0, 1);
    chk("ow1_empty", e1, 1);
    chk("ow1_unf", un1, 0);

    // fill to 5, then 10 cycles of simultaneous read and write
    wr_en = 1'b1;
    for (int k = 100; k < 105; k++) begin
      set_wr(k);
      step();
    end
    chk("rw_count_pre", c0, 5);
    rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_wr(105 + k);
      step();
      chk("rw_valid", v0, 1);
      chk("rw_ts", t0, 64'(100 + k));
      chk("rw_count", c0, 5);
    end
    rd_en = 1'b0;
    for (int k = 115; k < 118; k++) begin
      set_wr(k);
      step();
    end
    chk("fl_count_pre", c0, 8);

    // flush wins over a same-cycle write
    set_wr(200);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("fl_count", c0, 0);
    chk("fl_empty", e0, 1);
    chk("fl_valid", v0, 0);
    chk("fl_ts_hold", t0, 109);
    chk("fl_ovf_kept", ov0, 1);
    step();
    chk("fl_nothing_written", c0, 0);

    // underflow, clear, then write+read on empty
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("uf_flag", un0, 1);
    chk("uf_valid", v0, 0);
    chk("uf_count", c0, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_unf", un0, 0);
    chk("clr_ovf", ov0, 0);
    set_wr(300);
    wr_en = 1'b1;
    rd_en = 1'b1;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wr_empty_count", c0, 1);
    chk("wr_empty_unf", un0, 1);
    chk("wr_empty_valid", v0, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("wr_empty_read", t0, 300);
    chk("wr_empty_valid2", v0, 1);

    // reset in the middle of traffic
    wr_en = 1'b1;
    for (int k = 400; k < 404; k++) begin
      set_wr(k);
      step();
    end
    chk("pre_rst_count", c0, 4);
    rd_en = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("mrst_count", c0, 0);
    chk("mrst_empty", e0, 1);
    chk("mrst_valid", v0, 0);
    chk("mrst_dout", d0, 0);
    chk("mrst_ts", t0, 0);
    chk("mrst_unf", un0, 0);
    chk("mrst_count1", c1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/quaternion_ts_fifo.md
Name: quaternion_ts_fifo

Overview:
Parametrised successor to the single-channel quaternion buffer. Stores quaternion words with a capture timestamp, exposes occupancy, almost-full and sticky error flags, and offers a selectable drop-oldest overwrite mode. It sits between the IMU quaternion producer and the fusion timestamp aligner. Simultaneous read and write keep an exact count, and the block supports a synchronous flush.

Parameters:
DATA_W, 64, quaternion word width (4 x 16-bit components)
TS_W, 32, timestamp width
DEPTH, 16, number of entries; any value >= 2, not required to be a power of two
PTR_W, $clog2(DEPTH), pointer width (derived)
AFULL_THRESH, DEPTH-2, occupancy at or above which almost_full asserts
OVERWRITE, 0, 0 = drop new write when full; 1 = overwrite oldest entry when full

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_en  in  1  write request
data_in  in  DATA_W  quaternion to store
ts_in  in  TS_W  timestamp paired with data_in
rd_en  in  1  read request
flush  in  1  synchronous clear of contents
clr_err  in  1  clears the sticky overflow and underflow flags
data_out  out  DATA_W  registered read data
ts_out  out  TS_W  registered read timestamp
valid_out  out  1  one-cycle pulse: data_out and ts_out updated this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
count  out  PTR_W+1  current occupancy
overflow  out  1  sticky: a write hit a full FIFO (dropped or overwrote)
underflow  out  1  sticky: rd_en asserted while empty

Behaviour:
- Reset (rst_n low at a clk edge): pointers, count, data_out, ts_out, valid_out, overflow and underflow all go to 0. Memory is not cleared. Reset has priority over everything, including mid-operation traffic.
- Fire conditions:
  - rd_fire = rd_en & !empty.
  - wr_fire = wr_en & (!full | rd_fire | OVERWRITE).
- Read:
  - On rd_fire, data_out/ts_out <= mem[rd_ptr] and valid_out <= 1. Latency is 1 cycle from rd_en.
  - Otherwise valid_out <= 0 and data_out/ts_out hold their previous values.
- Write: on wr_fire, mem[wr_ptr] <= {ts_in, data_in}.
- Pointers: advance on their fire and wrap DEPTH-1 -> 0.
- Count:
  - +1 on wr_fire only.
  - -1 on rd_fire only.
  - Unchanged when both fire.
- Full with wr_en and no rd_fire:
  - OVERWRITE=0: write dropped, count stays DEPTH, overflow <= 1.
  - OVERWRITE=1: write stored at wr_ptr, rd_ptr also advances (oldest entry discarded), count stays DEPTH, overflow <= 1.
- Empty with wr_en and rd_en in the same cycle:
  - Write stored; the read does not fire (no bypass).
  - valid_out = 0, underflow <= 1.
  - The data becomes readable the next cycle.
- rd_en while empty: underflow <= 1, no pointer change.
- flush: wr_ptr, rd_ptr and count go to 0, and valid_out <= 0. Same-cycle wr_en and rd_en are ignored. data_out/ts_out hold. Sticky flags are unaffected.
- clr_err: clears overflow and underflow. An error event in the same cycle wins, so the flag stays set.
- full, empty, almost_full and count are combinational from the count register.

Optional Feature:
Macro QTS_FIFO_STATS_EN.
- Defined: adds outputs drop_cnt (16 bits) and peak_cnt (PTR_W+1 bits).
  - drop_cnt increments on every overflow event (dropped or overwritten write) and saturates at 16'hFFFF.
  - peak_cnt is the maximum count seen so far.
  - Both are cleared by reset and clr_err. flush does not clear them.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- After reset, write 3 entries (data 0x1111..., ts 10/20/30), then assert rd_en for 3 cycles -> valid_out pulses 1 cycle after each rd_en, outputs appear in order with ts 10/20/30, count goes 3 -> 0 and empty=1.
- DEPTH=16, OVERWRITE=0: write 17 entries with ts 0..16 -> full=1 and overflow=1; reading 16 entries returns ts 0..15, i.e. entry 16 was dropped.
- OVERWRITE=1: same 17 writes -> count=16, overflow=1; reads return ts 1..16.
- With count=5, hold wr_en and rd_en together for 10 cycles -> count stays 5, and 10 valid_out pulses return data in FIFO order.
- On an empty FIFO, assert rd_en alone -> underflow=1, valid_out=0. Then assert clr_err -> underflow=0. Then assert wr_en and rd_en together -> count=1 and underflow=1.
- With count=8, assert flush together with wr_en=1 -> next cycle count=0, empty=1, nothing written; assert rst_n=0 with count=4 -> all outputs return to 0 on the next edge.
